// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
// Shared types and helpers for the async-FIFO read-side arbiter.
//   state_t  : arbiter FSM states (IDLE, XFER)
//   RR_MAX   : widest requester vector rr_pick accepts
//   rr_pick  : round-robin pick; returns a one-hot vector (or zero) for
//              the first requester at or after ptr, wrapping modulo nreq
package fifo_rd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int RR_MAX = 32;

  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] req_v,
    input int unsigned       nreq,
    input int unsigned       ptr
  );
    logic [RR_MAX-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      if (i < nreq) begin
        // ptr < nreq and i < nreq, so one subtraction is enough to wrap
        idx = ptr + i;
        if (idx >= nreq) begin
          idx = idx - nreq;
        end else begin
          idx = idx;
        end
        if (!found && req_v[idx[4:0]]) begin
          pick[idx[4:0]] = 1'b1;
          found          = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr.sv
// rr_arbiter
// Round-robin requester selection with a registered priority pointer.
// Ports:
//   rclk, rrst_n : read-domain clock, asynchronous active-low reset
//   req          : per-consumer request vector
//   advance      : the pick is being taken; move rr_ptr past the winner
//   pick         : one-hot winner (zero when no request), combinational
module rr_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] pick
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     rr_ptr_q;
  logic [PW-1:0]     rr_ptr_d;
  logic [PW-1:0]     sel_idx;
  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] pick_ext;

  // Pick the first requester at or after rr_ptr and encode its index.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick_ext           = rr_pick(req_ext, NREQ, int'(rr_ptr_q));
    pick               = pick_ext[NREQ-1:0];
    sel_idx            = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (pick_ext[i]) begin
        sel_idx = PW'(i);
      end else begin
        sel_idx = sel_idx;
      end
    end
  end

  // After a taken pick, the requester following the winner gets top priority.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && (|pick)) begin
      if (sel_idx == PW'(NREQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = sel_idx + PW'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
// Shares the async FIFO read port among NREQ consumers. A round-robin
// winner owns the port for up to MAX_BURST words, then the block returns
// to IDLE for one arbitration cycle.
// Ports:
//   rclk, rrst_n : read-domain clock, asynchronous active-low reset
//   fifo_rempty  : FIFO empty flag
//   fifo_rdata   : FIFO word at the read address
//   fifo_rinc    : pop strobe, high on every accepted beat
//   req          : per-consumer request (level)
//   out_ready    : per-consumer accept
//   out_valid    : per-consumer valid, one-hot or zero
//   out_data     : broadcast of fifo_rdata
//   out_last     : current valid beat is the last of the burst
//   grant        : registered one-hot owner, zero in IDLE
module fifo_rd_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             fifo_rempty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  out_ready,
  output logic [NREQ-1:0]  out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  output logic [NREQ-1:0]  grant
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t          state_q;
  state_t          state_d;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] grant_d;
  logic [CW-1:0]   beat_cnt_q;
  logic [CW-1:0]   beat_cnt_d;

  logic [NREQ-1:0] pick_s;
  logic            arb_advance_s;
  logic            owner_req_s;
  logic            beat_s;
  logic            final_cnt_s;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .req     (req),
    .advance (arb_advance_s),
    .pick    (pick_s)
  );

  // Datapath gating: valid only for the owner while it requests and data exists.
  always_comb begin
    owner_req_s = |(grant_q & req);
    final_cnt_s = (beat_cnt_q == CW'(MAX_BURST - 1));
    if (state_q == XFER) begin
      out_valid = grant_q & req & {NREQ{~fifo_rempty}};
    end else begin
      out_valid = '0;
    end
    // A beat needs valid, so it can never pop an empty FIFO.
    beat_s    = |(out_valid & out_ready);
    fifo_rinc = beat_s;
    out_last  = (|out_valid) & final_cnt_s;
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in XFER.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    arb_advance_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d       = XFER;
          grant_d       = pick_s;
          beat_cnt_d    = '0;
          arb_advance_s = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      XFER: begin
        if (!owner_req_s) begin
          // owner withdrew: end the burst early
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
        end else if (beat_s) begin
          if (final_cnt_s) begin
            state_d    = IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end else begin
          // empty FIFO or consumer stall: keep the grant and wait
          state_d = XFER;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  // FSM, grant and beat counter registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign out_data = fifo_rdata;

endmodule
